// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_controller
// Brief   : Sequencing FSM and ALU decoder for a multicycle RV32I datapath
//           with req/ready memory handshake and optional timeout watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_op,
  output logic       err,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_ERROR    = 4'd15;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam int          CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] wdog_q, wdog_d;
  logic          w_mem_phase;
  logic          w_mem_wait;
  logic          w_timeout;
  logic [2:0]    w_rialu;
  logic          w_unused;

  assign w_unused    = ^{funct7[6], funct7[4:0]};
  assign w_mem_phase = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign w_mem_wait  = w_mem_phase && !mem_ready;
  // Expires on the wait cycle that brings the count to TIMEOUT; a ready in that cycle wins.
  assign w_timeout   = (TIMEOUT != 0) && w_mem_wait && (wdog_q == WD_LAST);
  assign state       = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_MEMWB:    state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_FETCH;
    endcase
    if (w_timeout) state_d = S_ERROR;

    wdog_d = wdog_q;
    if (state_d != state_q)              wdog_d = '0;
    else if (TIMEOUT != 0 && w_mem_wait) wdog_d = wdog_q + 1'b1;
  end

  always_comb begin
    case (funct3)
      3'b000:  w_rialu = (Op[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  w_rialu = ALU_SLT;
      3'b110:  w_rialu = ALU_OR;
      3'b111:  w_rialu = ALU_AND;
      default: w_rialu = ALU_ADD;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    illegal_op = 1'b0;
    err        = 1'b0;
    case (Op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        illegal_op = !(Op == OP_LW || Op == OP_SW || Op == OP_R ||
                       Op == OP_I  || Op == OP_BEQ || Op == OP_JAL);
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = w_rialu;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = w_rialu;
      end
      S_ALUWB:  RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = Zero;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_ERROR:  err = 1'b1;
      default: ;
    endcase

    // Reset overrides every strobe so nothing reaches the datapath or memory.
    if (!rst) begin
      mem_req    = 1'b0;
      PCWrite    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      illegal_op = 1'b0;
      err        = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_controller
// Brief   : Directed and random checks of multicycle_controller against an
//           instruction-level model of its sequencing and output rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  localparam int TMO = 4;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] Op = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op, err;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;
  logic [22:0] dut_o;

  int errors = 0;
  int checks = 0;
  int m_state = 0;
  int m_wait  = 0;

  multicycle_controller #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .illegal_op(illegal_op), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  // Bit layout: mem_req[22] PCWrite[21] AdrSrc[20] MemWrite[19] IRWrite[18] RegWrite[17]
  // ResultSrc[16:15] ALUSrcA[14:13] ALUSrcB[12:11] ImmSrc[10:9] ALUControl[8:6] ill[5] err[4] state[3:0]
  assign dut_o = {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_op, err, state};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit is_mem_state(int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  function automatic logic [2:0] alu_of(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
    if (f3 == 3'd0) return (op == RT && f7[5]) ? 3'b001 : 3'b000;
    if (f3 == 3'd2) return 3'b101;
    if (f3 == 3'd6) return 3'b011;
    if (f3 == 3'd7) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic [22:0] model_out(int s, logic [6:0] op, logic [2:0] f3,
                                            logic [6:0] f7, logic z, logic rdy, logic rv);
    logic mreq = 0, pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0, er = 0;
    logic [1:0] res = 0, a = 0, b = 0, imm = 0;
    logic [2:0] alu = 3'b000;
    logic [3:0] s4 = s[3:0];
    imm = (op == SW) ? 2'd1 : (op == BQ) ? 2'd2 : (op == JL) ? 2'd3 : 2'd0;
    case (s)
      0:  begin mreq = 1; b = 2; res = 2; irw = rdy; pcw = rdy; end
      1:  begin a = 1; b = 1; ill = !(op inside {LW, SW, RT, IT, BQ, JL}); end
      2:  begin a = 2; b = 1; end
      3:  begin mreq = 1; adr = 1; end
      4:  begin res = 1; rw = 1; end
      5:  begin mreq = 1; adr = 1; mw = 1; end
      6:  begin a = 2; alu = alu_of(op, f3, f7); end
      7:  begin a = 2; b = 1; alu = alu_of(op, f3, f7); end
      8:  rw = 1;
      9:  begin a = 2; alu = 3'b001; pcw = z; end
      10: begin a = 1; b = 2; pcw = 1; end
      15: er = 1;
      default: ;
    endcase
    if (!rv) {mreq, pcw, mw, irw, rw, ill, er} = '0;
    return {mreq, pcw, adr, mw, irw, rw, res, a, b, imm, alu, ill, er, s4};
  endfunction

  function automatic int model_next(int s, logic [6:0] op, logic rdy, int w);
    if (is_mem_state(s) && !rdy && w + 1 >= TMO) return 15;
    case (s)
      0:  return rdy ? 1 : 0;
      1:  begin
            if (op == LW || op == SW) return 2;
            if (op == RT) return 6;
            if (op == IT) return 7;
            if (op == BQ) return 9;
            if (op == JL) return 10;
            return 0;
          end
      2:  return (op == SW) ? 5 : 3;
      3:  return rdy ? 4 : 3;
      5:  return rdy ? 0 : 5;
      6, 7, 10: return 8;
      15: return 15;
      default: return 0;
    endcase
  endfunction

  // One clock cycle: entered and left at posedge+1; outputs compared mid-cycle.
  task automatic cyc(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic z, input logic rdy, output logic [22:0] got);
    int nxt;
    Op = op; funct3 = f3; funct7 = f7; Zero = z; mem_ready = rdy;
    #3;
    got = dut_o;
    check("outputs", {9'd0, got}, {9'd0, model_out(m_state, op, f3, f7, z, rdy, rst)});
    nxt = model_next(m_state, op, rdy, m_wait);
    if (nxt != m_state) m_wait = 0;
    else if (is_mem_state(m_state) && !rdy) m_wait++;
    @(posedge clk); #1;
    m_state = nxt;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    m_state = 0; m_wait = 0;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_strobes", {25'd0, mem_req, PCWrite, MemWrite, IRWrite, RegWrite, illegal_op, err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin : main
    logic [22:0] g;
    logic [19:0] seq;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    int          cnt_mw, cnt_rw, err_cycles;

    mem_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_strobes", {25'd0, mem_req, PCWrite, MemWrite, IRWrite, RegWrite, illegal_op, err}, 32'd0);
    rst = 1'b1;

    // lw with zero-wait memory
    seq = '0;
    for (int i = 0; i < 5; i++) begin
      cyc(LW, 3'd2, 7'd0, 1'b0, 1'b1, g);
      seq = {seq[15:0], g[3:0]};
      if (i == 4) check("lw_memwb_rw_res", {29'd0, g[17], g[16:15]}, 32'b101);
    end
    check("lw_seq", {12'd0, seq}, 32'h01234);
    check("lw_back_fetch", {28'd0, state}, 32'd0);

    // sw with three wait cycles in MEMWRITE
    cnt_mw = 0; cnt_rw = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(SW, 3'd2, 7'd0, 1'b0, !(i >= 3 && i <= 5), g);
      cnt_mw += g[19];
      cnt_rw += g[17];
    end
    check("sw_memwrite_cycles", cnt_mw, 32'd4);
    check("sw_no_regwrite", cnt_rw, 32'd0);
    check("sw_back_fetch", {28'd0, state}, 32'd0);

    // R-type ALU decode captured in EXECUTER
    for (int k = 0; k < 3; k++) begin
      f7 = (k == 0) ? 7'b0100000 : 7'd0;
      f3 = (k == 2) ? 3'b110 : 3'b000;
      for (int i = 0; i < 4; i++) begin
        cyc(RT, f3, f7, 1'b0, 1'b1, g);
        if (i == 2) check("rtype_alu", {29'd0, g[8:6]}, (k == 0) ? 32'd1 : (k == 1) ? 32'd0 : 32'd3);
      end
    end

    // beq taken and not taken
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        cyc(BQ, 3'd0, 7'd0, (k == 0), 1'b1, g);
        if (i == 2) check("beq_pcwrite", {31'd0, g[21]}, (k == 0) ? 32'd1 : 32'd0);
      end
      check("beq_back_fetch", {28'd0, state}, 32'd0);
    end

    // unsupported opcode
    cyc(7'd0, 3'd0, 7'd0, 1'b0, 1'b1, g);
    cyc(7'd0, 3'd0, 7'd0, 1'b0, 1'b1, g);
    check("illegal_pulse", {31'd0, g[5]}, 32'd1);
    check("illegal_no_writes", {28'd0, g[21], g[19], g[18], g[17]}, 32'd0);
    check("illegal_back_fetch", {28'd0, state}, 32'd0);

    // watchdog: fetch stuck
    for (int i = 0; i < 3; i++) cyc(LW, 3'd0, 7'd0, 1'b0, 1'b0, g);
    check("wdog_not_yet", {28'd0, state}, 32'd0);
    cyc(LW, 3'd0, 7'd0, 1'b0, 1'b0, g);
    check("wdog_error_state", {28'd0, state}, 32'd15);
    #3;
    check("wdog_err_flag", {31'd0, err}, 32'd1);
    #4;
    cyc(LW, 3'd0, 7'd0, 1'b0, 1'b1, g);
    do_reset();

    // reset in the middle of MEMREAD
    for (int i = 0; i < 3; i++) cyc(LW, 3'd0, 7'd0, 1'b0, 1'b1, g);
    cyc(LW, 3'd0, 7'd0, 1'b0, 1'b0, g);
    check("memread_before_rst", {28'd0, state}, 32'd3);
    do_reset();
    check("rst_clears_err", {31'd0, err}, 32'd0);

    // random instruction stream with random memory stalls, branch flags and opcodes
    op = LW; f3 = '0; f7 = '0; err_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_state == 0) begin
        case ($urandom_range(0, 6))
          0: op = LW;  1: op = SW;  2: op = RT;  3: op = IT;
          4: op = BQ;  5: op = JL;  default: op = 7'($urandom);
        endcase
        f3 = 3'($urandom);
        f7 = 7'($urandom);
      end
      if (m_state == 15) begin
        err_cycles++;
        if (err_cycles > 3) begin
          err_cycles = 0;
          do_reset();
          continue;
        end
      end
      cyc(op, f3, f7, 1'($urandom), ($urandom_range(0, 9) < 7), g);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
